// File: rtl/axi4lite_pkg.sv
// Shared AXI4-lite definitions: arbiter FSM states, response codes and width helpers.
package axi4lite_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int PROT_W = 3;
   localparam int RESP_W = 2;

   function automatic int data_w_of(input int byte_w);
      return 8 * byte_w;
   endfunction

endpackage

// File: rtl/axi4lite_arbiter2_picker.sv
// Two-way request picker (module arb2_picker); round-robin when AXI4LITE_ARBITER2_ROUNDROBIN_EN
// is defined, otherwise fixed priority with m0 favoured.
module arb2_picker
   import axi4lite_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       en,
   output logic [1:0] gnt
);

`ifdef AXI4LITE_ARBITER2_ROUNDROBIN_EN
   always_comb begin
      gnt = '0;
      if (en) begin
         // on a tie the master that did not win last time goes first
         if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
         else              gnt = req;
      end
   end
`else
   logic unused_last;
   assign unused_last = last;

   always_comb begin
      gnt = '0;
      if (en) begin
         if (req == 2'b11) gnt = 2'b01;
         else              gnt = req;
      end
   end
`endif

endmodule

// File: rtl/axi4lite_arbiter2.sv
// Two-master to one-slave AXI4-lite arbiter with independent write and read paths.
// Define AXI4LITE_ARBITER2_ROUNDROBIN_EN for round-robin ties; default is fixed priority (m0).
module axi4lite_arbiter2
   import axi4lite_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_BYTEW = 4,
   parameter int ID_W       = 4,
   localparam int DATA_W    = 8 * DATA_BYTEW
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   // master 0
   input  logic [ID_W-1:0]       i_m0_axi_AWID,
   input  logic [ADDR_W-1:0]     i_m0_axi_AWADDR,
   input  logic [2:0]            i_m0_axi_AWPROT,
   input  logic                  i_m0_axi_AWVALID,
   output logic                  o_m0_axi_AWREADY,
   input  logic [DATA_W-1:0]     i_m0_axi_WDATA,
   input  logic [DATA_BYTEW-1:0] i_m0_axi_WSTRB,
   input  logic                  i_m0_axi_WVALID,
   output logic                  o_m0_axi_WREADY,
   output logic [ID_W-1:0]       o_m0_axi_BID,
   output logic [1:0]            o_m0_axi_BRESP,
   output logic                  o_m0_axi_BVALID,
   input  logic                  i_m0_axi_BREADY,
   input  logic [ID_W-1:0]       i_m0_axi_ARID,
   input  logic [ADDR_W-1:0]     i_m0_axi_ARADDR,
   input  logic [2:0]            i_m0_axi_ARPROT,
   input  logic                  i_m0_axi_ARVALID,
   output logic                  o_m0_axi_ARREADY,
   output logic [ID_W-1:0]       o_m0_axi_RID,
   output logic [DATA_W-1:0]     o_m0_axi_RDATA,
   output logic [1:0]            o_m0_axi_RRESP,
   output logic                  o_m0_axi_RVALID,
   input  logic                  i_m0_axi_RREADY,
   // master 1
   input  logic [ID_W-1:0]       i_m1_axi_AWID,
   input  logic [ADDR_W-1:0]     i_m1_axi_AWADDR,
   input  logic [2:0]            i_m1_axi_AWPROT,
   input  logic                  i_m1_axi_AWVALID,
   output logic                  o_m1_axi_AWREADY,
   input  logic [DATA_W-1:0]     i_m1_axi_WDATA,
   input  logic [DATA_BYTEW-1:0] i_m1_axi_WSTRB,
   input  logic                  i_m1_axi_WVALID,
   output logic                  o_m1_axi_WREADY,
   output logic [ID_W-1:0]       o_m1_axi_BID,
   output logic [1:0]            o_m1_axi_BRESP,
   output logic                  o_m1_axi_BVALID,
   input  logic                  i_m1_axi_BREADY,
   input  logic [ID_W-1:0]       i_m1_axi_ARID,
   input  logic [ADDR_W-1:0]     i_m1_axi_ARADDR,
   input  logic [2:0]            i_m1_axi_ARPROT,
   input  logic                  i_m1_axi_ARVALID,
   output logic                  o_m1_axi_ARREADY,
   output logic [ID_W-1:0]       o_m1_axi_RID,
   output logic [DATA_W-1:0]     o_m1_axi_RDATA,
   output logic [1:0]            o_m1_axi_RRESP,
   output logic                  o_m1_axi_RVALID,
   input  logic                  i_m1_axi_RREADY,
   // slave
   output logic [ID_W-1:0]       o_s_axi_AWID,
   output logic [ADDR_W-1:0]     o_s_axi_AWADDR,
   output logic [2:0]            o_s_axi_AWPROT,
   output logic                  o_s_axi_AWVALID,
   input  logic                  i_s_axi_AWREADY,
   output logic [DATA_W-1:0]     o_s_axi_WDATA,
   output logic [DATA_BYTEW-1:0] o_s_axi_WSTRB,
   output logic                  o_s_axi_WVALID,
   input  logic                  i_s_axi_WREADY,
   input  logic [ID_W-1:0]       i_s_axi_BID,
   input  logic [1:0]            i_s_axi_BRESP,
   input  logic                  i_s_axi_BVALID,
   output logic                  o_s_axi_BREADY,
   output logic [ID_W-1:0]       o_s_axi_ARID,
   output logic [ADDR_W-1:0]     o_s_axi_ARADDR,
   output logic [2:0]            o_s_axi_ARPROT,
   output logic                  o_s_axi_ARVALID,
   input  logic                  i_s_axi_ARREADY,
   input  logic [ID_W-1:0]       i_s_axi_RID,
   input  logic [DATA_W-1:0]     i_s_axi_RDATA,
   input  logic [1:0]            i_s_axi_RRESP,
   input  logic                  i_s_axi_RVALID,
   output logic                  o_s_axi_RREADY,
   // grants
   output logic [1:0]            o_wr_gnt,
   output logic [1:0]            o_rd_gnt
);

   arb_state_t wr_state, wr_next, rd_state, rd_next;
   logic [1:0] wr_gnt, wr_pick, rd_gnt, rd_pick;
   logic       aw_done, w_done;
   logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic       wr_last, rd_last;

   assign aw_hs = o_s_axi_AWVALID & i_s_axi_AWREADY;
   assign w_hs  = o_s_axi_WVALID  & i_s_axi_WREADY;
   assign b_hs  = o_s_axi_BREADY  & i_s_axi_BVALID;
   assign ar_hs = o_s_axi_ARVALID & i_s_axi_ARREADY;
   assign r_hs  = o_s_axi_RREADY  & i_s_axi_RVALID;

   assign o_wr_gnt = wr_gnt;
   assign o_rd_gnt = rd_gnt;

`ifdef AXI4LITE_ARBITER2_ROUNDROBIN_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_last <= 1'b1;
         rd_last <= 1'b1;
      end else begin
         if (b_hs) wr_last <= wr_gnt[1];
         if (r_hs) rd_last <= rd_gnt[1];
      end
   end
`else
   assign wr_last = 1'b1;
   assign rd_last = 1'b1;
`endif

   arb2_picker u_wr_pick (
      .req  ({i_m1_axi_AWVALID, i_m0_axi_AWVALID}),
      .last (wr_last),
      .en   (wr_state == IDLE),
      .gnt  (wr_pick)
   );

   arb2_picker u_rd_pick (
      .req  ({i_m1_axi_ARVALID, i_m0_axi_ARVALID}),
      .last (rd_last),
      .en   (rd_state == IDLE),
      .gnt  (rd_pick)
   );

   // ---------------- write path ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_state <= IDLE;
         wr_gnt   <= '0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
      end else begin
         wr_state <= wr_next;
         case (wr_state)
            IDLE: begin
               wr_gnt  <= wr_pick;
               aw_done <= 1'b0;
               w_done  <= 1'b0;
            end
            ADDR: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs)  w_done  <= 1'b1;
            end
            RESP:    if (b_hs) wr_gnt <= '0;
            default: ;
         endcase
      end
   end

   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         IDLE:    if (|wr_pick) wr_next = ADDR;
         ADDR:    if ((aw_done | aw_hs) && (w_done | w_hs)) wr_next = RESP;
         RESP:    if (b_hs) wr_next = IDLE;
         default: wr_next = IDLE;
      endcase
   end

   always_comb begin
      o_s_axi_AWID     = wr_gnt[1] ? i_m1_axi_AWID   : i_m0_axi_AWID;
      o_s_axi_AWADDR   = wr_gnt[1] ? i_m1_axi_AWADDR : i_m0_axi_AWADDR;
      o_s_axi_AWPROT   = wr_gnt[1] ? i_m1_axi_AWPROT : i_m0_axi_AWPROT;
      o_s_axi_WDATA    = wr_gnt[1] ? i_m1_axi_WDATA  : i_m0_axi_WDATA;
      o_s_axi_WSTRB    = wr_gnt[1] ? i_m1_axi_WSTRB  : i_m0_axi_WSTRB;
      o_s_axi_AWVALID  = 1'b0;
      o_s_axi_WVALID   = 1'b0;
      o_s_axi_BREADY   = 1'b0;
      o_m0_axi_AWREADY = 1'b0;
      o_m1_axi_AWREADY = 1'b0;
      o_m0_axi_WREADY  = 1'b0;
      o_m1_axi_WREADY  = 1'b0;
      o_m0_axi_BVALID  = 1'b0;
      o_m1_axi_BVALID  = 1'b0;
      o_m0_axi_BID     = '0;
      o_m1_axi_BID     = '0;
      o_m0_axi_BRESP   = '0;
      o_m1_axi_BRESP   = '0;
      case (wr_state)
         ADDR: begin
            // a channel that already handshook is masked so it cannot transfer twice
            o_s_axi_AWVALID  = !aw_done && (wr_gnt[1] ? i_m1_axi_AWVALID : i_m0_axi_AWVALID);
            o_s_axi_WVALID   = !w_done  && (wr_gnt[1] ? i_m1_axi_WVALID  : i_m0_axi_WVALID);
            o_m0_axi_AWREADY = wr_gnt[0] && !aw_done && i_s_axi_AWREADY;
            o_m1_axi_AWREADY = wr_gnt[1] && !aw_done && i_s_axi_AWREADY;
            o_m0_axi_WREADY  = wr_gnt[0] && !w_done  && i_s_axi_WREADY;
            o_m1_axi_WREADY  = wr_gnt[1] && !w_done  && i_s_axi_WREADY;
         end
         RESP: begin
            o_s_axi_BREADY = wr_gnt[1] ? i_m1_axi_BREADY : i_m0_axi_BREADY;
            if (wr_gnt[0]) begin
               o_m0_axi_BVALID = i_s_axi_BVALID;
               o_m0_axi_BID    = i_s_axi_BID;
               o_m0_axi_BRESP  = i_s_axi_BRESP;
            end
            if (wr_gnt[1]) begin
               o_m1_axi_BVALID = i_s_axi_BVALID;
               o_m1_axi_BID    = i_s_axi_BID;
               o_m1_axi_BRESP  = i_s_axi_BRESP;
            end
         end
         default: ;
      endcase
   end

   // ---------------- read path ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_state <= IDLE;
         rd_gnt   <= '0;
      end else begin
         rd_state <= rd_next;
         case (rd_state)
            IDLE:    rd_gnt <= rd_pick;
            RESP:    if (r_hs) rd_gnt <= '0;
            default: ;
         endcase
      end
   end

   // ADDR leaves on the AR handshake itself, so no done flag is needed here
   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         IDLE:    if (|rd_pick) rd_next = ADDR;
         ADDR:    if (ar_hs) rd_next = RESP;
         RESP:    if (r_hs) rd_next = IDLE;
         default: rd_next = IDLE;
      endcase
   end

   always_comb begin
      o_s_axi_ARID     = rd_gnt[1] ? i_m1_axi_ARID   : i_m0_axi_ARID;
      o_s_axi_ARADDR   = rd_gnt[1] ? i_m1_axi_ARADDR : i_m0_axi_ARADDR;
      o_s_axi_ARPROT   = rd_gnt[1] ? i_m1_axi_ARPROT : i_m0_axi_ARPROT;
      o_s_axi_ARVALID  = 1'b0;
      o_s_axi_RREADY   = 1'b0;
      o_m0_axi_ARREADY = 1'b0;
      o_m1_axi_ARREADY = 1'b0;
      o_m0_axi_RVALID  = 1'b0;
      o_m1_axi_RVALID  = 1'b0;
      o_m0_axi_RID     = '0;
      o_m1_axi_RID     = '0;
      o_m0_axi_RDATA   = '0;
      o_m1_axi_RDATA   = '0;
      o_m0_axi_RRESP   = '0;
      o_m1_axi_RRESP   = '0;
      case (rd_state)
         ADDR: begin
            o_s_axi_ARVALID  = rd_gnt[1] ? i_m1_axi_ARVALID : i_m0_axi_ARVALID;
            o_m0_axi_ARREADY = rd_gnt[0] && i_s_axi_ARREADY;
            o_m1_axi_ARREADY = rd_gnt[1] && i_s_axi_ARREADY;
         end
         RESP: begin
            o_s_axi_RREADY = rd_gnt[1] ? i_m1_axi_RREADY : i_m0_axi_RREADY;
            if (rd_gnt[0]) begin
               o_m0_axi_RVALID = i_s_axi_RVALID;
               o_m0_axi_RID    = i_s_axi_RID;
               o_m0_axi_RDATA  = i_s_axi_RDATA;
               o_m0_axi_RRESP  = i_s_axi_RRESP;
            end
            if (rd_gnt[1]) begin
               o_m1_axi_RVALID = i_s_axi_RVALID;
               o_m1_axi_RID    = i_s_axi_RID;
               o_m1_axi_RDATA  = i_s_axi_RDATA;
               o_m1_axi_RRESP  = i_s_axi_RRESP;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi4lite_arbiter2.sv
// Self-checking bench for axi4lite_arbiter2: table of single transactions plus directed corner sequences.
module tb_axi4lite_arbiter2;
   import axi4lite_pkg::*;

   logic clk, rst;

   logic [3:0]  m_awid[2];   logic [15:0] m_awaddr[2]; logic [2:0] m_awprot[2];
   logic        m_awvalid[2];
   logic [31:0] m_wdata[2];  logic [3:0]  m_wstrb[2];  logic       m_wvalid[2];
   logic        m_bready[2];
   logic [3:0]  m_arid[2];   logic [15:0] m_araddr[2]; logic [2:0] m_arprot[2];
   logic        m_arvalid[2];
   logic        m_rready[2];
   wire         m_awready[2], m_wready[2], m_bvalid[2], m_arready[2], m_rvalid[2];
   wire  [3:0]  m_bid[2], m_rid[2];
   wire  [1:0]  m_bresp[2], m_rresp[2];
   wire  [31:0] m_rdata[2];

   logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
   logic [3:0]  s_bid, s_rid;
   logic [1:0]  s_bresp, s_rresp;
   logic [31:0] s_rdata;
   wire  [3:0]  s_awid, s_arid;
   wire  [15:0] s_awaddr, s_araddr;
   wire  [2:0]  s_awprot, s_arprot;
   wire  [31:0] s_wdata;
   wire  [3:0]  s_wstrb;
   wire         s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
   wire  [1:0]  wr_gnt, rd_gnt;

   int n_vec = 0;
   int n_bad = 0;

   axi4lite_arbiter2 #(.ADDR_W(16), .DATA_BYTEW(4), .ID_W(4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_m0_axi_AWID(m_awid[0]), .i_m0_axi_AWADDR(m_awaddr[0]), .i_m0_axi_AWPROT(m_awprot[0]),
      .i_m0_axi_AWVALID(m_awvalid[0]), .o_m0_axi_AWREADY(m_awready[0]),
      .i_m0_axi_WDATA(m_wdata[0]), .i_m0_axi_WSTRB(m_wstrb[0]), .i_m0_axi_WVALID(m_wvalid[0]),
      .o_m0_axi_WREADY(m_wready[0]),
      .o_m0_axi_BID(m_bid[0]), .o_m0_axi_BRESP(m_bresp[0]), .o_m0_axi_BVALID(m_bvalid[0]),
      .i_m0_axi_BREADY(m_bready[0]),
      .i_m0_axi_ARID(m_arid[0]), .i_m0_axi_ARADDR(m_araddr[0]), .i_m0_axi_ARPROT(m_arprot[0]),
      .i_m0_axi_ARVALID(m_arvalid[0]), .o_m0_axi_ARREADY(m_arready[0]),
      .o_m0_axi_RID(m_rid[0]), .o_m0_axi_RDATA(m_rdata[0]), .o_m0_axi_RRESP(m_rresp[0]),
      .o_m0_axi_RVALID(m_rvalid[0]), .i_m0_axi_RREADY(m_rready[0]),
      .i_m1_axi_AWID(m_awid[1]), .i_m1_axi_AWADDR(m_awaddr[1]), .i_m1_axi_AWPROT(m_awprot[1]),
      .i_m1_axi_AWVALID(m_awvalid[1]), .o_m1_axi_AWREADY(m_awready[1]),
      .i_m1_axi_WDATA(m_wdata[1]), .i_m1_axi_WSTRB(m_wstrb[1]), .i_m1_axi_WVALID(m_wvalid[1]),
      .o_m1_axi_WREADY(m_wready[1]),
      .o_m1_axi_BID(m_bid[1]), .o_m1_axi_BRESP(m_bresp[1]), .o_m1_axi_BVALID(m_bvalid[1]),
      .i_m1_axi_BREADY(m_bready[1]),
      .i_m1_axi_ARID(m_arid[1]), .i_m1_axi_ARADDR(m_araddr[1]), .i_m1_axi_ARPROT(m_arprot[1]),
      .i_m1_axi_ARVALID(m_arvalid[1]), .o_m1_axi_ARREADY(m_arready[1]),
      .o_m1_axi_RID(m_rid[1]), .o_m1_axi_RDATA(m_rdata[1]), .o_m1_axi_RRESP(m_rresp[1]),
      .o_m1_axi_RVALID(m_rvalid[1]), .i_m1_axi_RREADY(m_rready[1]),
      .o_s_axi_AWID(s_awid), .o_s_axi_AWADDR(s_awaddr), .o_s_axi_AWPROT(s_awprot),
      .o_s_axi_AWVALID(s_awvalid), .i_s_axi_AWREADY(s_awready),
      .o_s_axi_WDATA(s_wdata), .o_s_axi_WSTRB(s_wstrb), .o_s_axi_WVALID(s_wvalid),
      .i_s_axi_WREADY(s_wready),
      .i_s_axi_BID(s_bid), .i_s_axi_BRESP(s_bresp), .i_s_axi_BVALID(s_bvalid),
      .o_s_axi_BREADY(s_bready),
      .o_s_axi_ARID(s_arid), .o_s_axi_ARADDR(s_araddr), .o_s_axi_ARPROT(s_arprot),
      .o_s_axi_ARVALID(s_arvalid), .i_s_axi_ARREADY(s_arready),
      .i_s_axi_RID(s_rid), .i_s_axi_RDATA(s_rdata), .i_s_axi_RRESP(s_rresp),
      .i_s_axi_RVALID(s_rvalid), .o_s_axi_RREADY(s_rready),
      .o_wr_gnt(wr_gnt), .o_rd_gnt(rd_gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      bit          wr;
      int          m;
      logic [3:0]  id;
      logic [15:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
      logic [1:0]  exp_gnt;
      logic [1:0]  exp_resp;
      logic [3:0]  exp_id;
      logic [31:0] exp_data;
      int          exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_all();
      for (int i = 0; i < 2; i++) begin
         m_awid[i] = '0; m_awaddr[i] = '0; m_awprot[i] = '0; m_awvalid[i] = 1'b0;
         m_wdata[i] = '0; m_wstrb[i] = '0; m_wvalid[i] = 1'b0; m_bready[i] = 1'b0;
         m_arid[i] = '0; m_araddr[i] = '0; m_arprot[i] = '0; m_arvalid[i] = 1'b0;
         m_rready[i] = 1'b0;
      end
      s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
      s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;
      s_rvalid = 1'b0; s_rid = '0; s_rresp = '0; s_rdata = '0;
   endtask

   // One complete transaction against a zero-stall slave that echoes the ID it saw.
   task automatic do_txn(input vec_t v, input string tag);
      int lat;
      logic seen;
      logic [3:0] cap_id;
      int o;
      o = 1 - v.m;
      s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
      s_bvalid = 1'b0; s_rvalid = 1'b0;
      if (v.wr) begin
         m_awid[v.m] = v.id; m_awaddr[v.m] = v.addr; m_awprot[v.m] = 3'd0; m_awvalid[v.m] = 1'b1;
         m_wdata[v.m] = v.data; m_wstrb[v.m] = 4'hf; m_wvalid[v.m] = 1'b1; m_bready[v.m] = 1'b1;
      end else begin
         m_arid[v.m] = v.id; m_araddr[v.m] = v.addr; m_arprot[v.m] = 3'd0; m_arvalid[v.m] = 1'b1;
         m_rready[v.m] = 1'b1;
      end
      lat = 0;
      #1;
      seen = v.wr ? s_awvalid : s_arvalid;
      while (!seen && lat < 8) begin
         @(negedge clk); #1;
         lat++;
         seen = v.wr ? s_awvalid : s_arvalid;
      end
      check({tag, ".latency"}, lat, v.exp_lat);
      if (v.wr) begin
         check({tag, ".wr_gnt"}, wr_gnt, v.exp_gnt);
         check({tag, ".s_awaddr"}, s_awaddr, v.addr);
         check({tag, ".s_wdata"}, s_wdata, v.exp_data);
         check({tag, ".own_rdy"}, {m_awready[v.m], m_wready[v.m]}, 2'b11);
         check({tag, ".other_rdy"}, {m_awready[o], m_wready[o]}, 2'b00);
         cap_id = s_awid;
      end else begin
         check({tag, ".rd_gnt"}, rd_gnt, v.exp_gnt);
         check({tag, ".s_araddr"}, s_araddr, v.addr);
         check({tag, ".own_rdy"}, m_arready[v.m], 1'b1);
         check({tag, ".other_rdy"}, m_arready[o], 1'b0);
         cap_id = s_arid;
      end
      @(negedge clk);
      if (v.wr) begin
         m_awvalid[v.m] = 1'b0; m_wvalid[v.m] = 1'b0;
         s_bid = cap_id; s_bresp = v.resp; s_bvalid = 1'b1;
         #1;
         check({tag, ".bvalid"}, {m_bvalid[v.m], m_bvalid[o]}, 2'b10);
         check({tag, ".bresp"}, m_bresp[v.m], v.exp_resp);
         check({tag, ".bid"}, m_bid[v.m], v.exp_id);
      end else begin
         m_arvalid[v.m] = 1'b0;
         s_rid = cap_id; s_rdata = v.data; s_rresp = v.resp; s_rvalid = 1'b1;
         #1;
         check({tag, ".rvalid"}, {m_rvalid[v.m], m_rvalid[o]}, 2'b10);
         check({tag, ".rresp"}, m_rresp[v.m], v.exp_resp);
         check({tag, ".rid"}, m_rid[v.m], v.exp_id);
         check({tag, ".rdata"}, m_rdata[v.m], v.exp_data);
      end
      @(negedge clk);
      s_bvalid = 1'b0; s_rvalid = 1'b0;
      m_bready[v.m] = 1'b0; m_rready[v.m] = 1'b0;
      #1;
      check({tag, ".gnt_clear"}, v.wr ? wr_gnt : rd_gnt, 2'b00);
   endtask

   vec_t vecs[5];
   logic [1:0] grants[4];
   int gtime[4];
   int ng, wcount;
   logic [1:0] prev_gnt;

   initial begin
      vecs[0] = '{1'b1, 0, 4'h3, 16'h0010, 32'hdeadbeef, RESP_OKAY,   2'b01, 2'b00, 4'h3, 32'hdeadbeef, 1};
      vecs[1] = '{1'b1, 1, 4'ha, 16'h0020, 32'h12345678, RESP_SLVERR, 2'b10, 2'b10, 4'ha, 32'h12345678, 1};
      vecs[2] = '{1'b0, 0, 4'h5, 16'h0100, 32'hcafef00d, RESP_OKAY,   2'b01, 2'b00, 4'h5, 32'hcafef00d, 1};
      vecs[3] = '{1'b0, 1, 4'hf, 16'h0200, 32'h0badc0de, RESP_DECERR, 2'b10, 2'b11, 4'hf, 32'h0badc0de, 1};
      vecs[4] = '{1'b1, 0, 4'h0, 16'hfffc, 32'h00ff00ff, RESP_EXOKAY, 2'b01, 2'b01, 4'h0, 32'h00ff00ff, 1};

      // reset
      rst = 1'b1;
      idle_all();
      repeat (3) @(negedge clk);
      #1;
      check("reset.ctrl", {m_awready[0], m_awready[1], m_wready[0], m_wready[1], m_bvalid[0],
            m_bvalid[1], m_arready[0], m_arready[1], m_rvalid[0], m_rvalid[1], s_awvalid,
            s_wvalid, s_bready, s_arvalid, s_rready, wr_gnt, rd_gnt}, 19'd0);
      check("reset.resp_fields", {m_bid[0], m_bid[1], m_bresp[0], m_bresp[1], m_rid[0], m_rid[1],
            m_rresp[0], m_rresp[1]}, 24'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         idle_all();
         do_txn(vecs[i], $sformatf("vec%0d", i));
         @(negedge clk);
      end

      // tie: both masters write continuously
      idle_all();
      s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_bresp = RESP_OKAY;
      for (int i = 0; i < 2; i++) begin
         m_awid[i] = 4'(i); m_awaddr[i] = 16'h1000 + 16'(i); m_awvalid[i] = 1'b1;
         m_wdata[i] = 32'h1111_0000 + 32'(i); m_wstrb[i] = 4'hf; m_wvalid[i] = 1'b1;
         m_bready[i] = 1'b1;
      end
      ng = 0; prev_gnt = 2'b00;
      for (int c = 0; c < 30 && ng < 4; c++) begin
         @(negedge clk); #1;
         if (wr_gnt != 2'b00 && prev_gnt == 2'b00) begin
            grants[ng] = wr_gnt; gtime[ng] = c; ng++;
         end
         prev_gnt = wr_gnt;
      end
      check("tie.count", ng, 4);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         m_awvalid[i] = 1'b0; m_wvalid[i] = 1'b0;
      end
      @(negedge clk);
      s_bvalid = 1'b0;
`ifdef AXI4LITE_ARBITER2_ROUNDROBIN_EN
      check("tie.g0", grants[0], 2'b01);
      check("tie.g1", grants[1], 2'b10);
      check("tie.g2", grants[2], 2'b01);
      check("tie.g3", grants[3], 2'b10);
`else
      check("tie.g0", grants[0], 2'b01);
      check("tie.g1", grants[1], 2'b01);
      check("tie.g2", grants[2], 2'b01);
      check("tie.g3", grants[3], 2'b01);
`endif
      check("tie.throughput", gtime[3] - gtime[0], 9);
      #1;
      check("tie.idle", wr_gnt, 2'b00);
      @(negedge clk);

      // W ahead of AW, slave takes AW two cycles before W
      idle_all();
      s_awready = 1'b1; s_wready = 1'b0;
      m_wdata[1] = 32'h5a5a0001; m_wstrb[1] = 4'hf; m_wvalid[1] = 1'b1; m_bready[1] = 1'b1;
      wcount = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("wfirst.pre%0d", c), {m_wready[1], s_wvalid, wr_gnt}, 4'b0000);
         @(negedge clk);
      end
      m_awid[1] = 4'h7; m_awaddr[1] = 16'h0030; m_awvalid[1] = 1'b1;
      @(negedge clk); #1;
      check("wfirst.gnt", wr_gnt, 2'b10);
      check("wfirst.addr_valids", {s_awvalid, s_wvalid, m_wready[1]}, 3'b110);
      if (s_wvalid && s_wready) wcount++;
      @(negedge clk); #1;
      check("wfirst.aw_masked", {s_awvalid, s_bready}, 2'b00);
      if (s_wvalid && s_wready) wcount++;
      @(negedge clk);
      s_wready = 1'b1;
      #1;
      check("wfirst.wready", {m_wready[1], s_bready}, 2'b10);
      if (s_wvalid && s_wready) wcount++;
      @(negedge clk); #1;
      check("wfirst.resp_bready", {s_bready, s_wvalid}, 2'b10);
      if (s_wvalid && s_wready) wcount++;
      m_awvalid[1] = 1'b0; m_wvalid[1] = 1'b0;
      s_bid = 4'h7; s_bresp = RESP_OKAY; s_bvalid = 1'b1;
      #1;
      check("wfirst.b", {m_bvalid[1], m_bid[1], m_bresp[1]}, {1'b1, 4'h7, 2'b00});
      @(negedge clk);
      s_bvalid = 1'b0;
      #1;
      check("wfirst.w_count", wcount, 1);
      check("wfirst.gnt_clear", wr_gnt, 2'b00);
      @(negedge clk);

      // concurrent m0 write and m1 read, read returns SLVERR
      idle_all();
      s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
      m_awid[0] = 4'h2; m_awaddr[0] = 16'h0040; m_awvalid[0] = 1'b1;
      m_wdata[0] = 32'ha5a5a5a5; m_wstrb[0] = 4'hf; m_wvalid[0] = 1'b1; m_bready[0] = 1'b1;
      m_arid[1] = 4'h9; m_araddr[1] = 16'h0080; m_arvalid[1] = 1'b1; m_rready[1] = 1'b1;
      @(negedge clk); #1;
      check("conc.gnts", {wr_gnt, rd_gnt}, 4'b0110);
      check("conc.s_valids", {s_awvalid, s_arvalid, s_arid}, {2'b11, 4'h9});
      @(negedge clk);
      m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0; m_arvalid[1] = 1'b0;
      s_bid = 4'h2; s_bresp = RESP_OKAY; s_bvalid = 1'b1;
      s_rid = 4'h9; s_rdata = 32'h600dd00d; s_rresp = RESP_SLVERR; s_rvalid = 1'b1;
      #1;
      check("conc.rresp", {m_rvalid[1], m_rvalid[0], m_rresp[1]}, {2'b10, 2'b10});
      check("conc.rdata", m_rdata[1], 32'h600dd00d);
      check("conc.b", {m_bvalid[0], m_bvalid[1], m_bresp[0]}, {2'b10, 2'b00});
      @(negedge clk);
      s_bvalid = 1'b0; s_rvalid = 1'b0;
      #1;
      check("conc.clear", {wr_gnt, rd_gnt}, 4'b0000);
      @(negedge clk);

      // reset while both paths wait in RESP
      idle_all();
      s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
      m_awid[0] = 4'h4; m_awaddr[0] = 16'h0050; m_awvalid[0] = 1'b1;
      m_wdata[0] = 32'h01020304; m_wstrb[0] = 4'hf; m_wvalid[0] = 1'b1; m_bready[0] = 1'b1;
      m_arid[1] = 4'h6; m_araddr[1] = 16'h0060; m_arvalid[1] = 1'b1; m_rready[1] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0; m_arvalid[1] = 1'b0;
      #1;
      check("mrst.in_resp", {wr_gnt, rd_gnt, s_bready, s_rready}, 6'b011011);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mrst.gnts", {wr_gnt, rd_gnt}, 4'b0000);
      s_bvalid = 1'b1; s_rvalid = 1'b1;
      #1;
      check("mrst.no_resp", {m_bvalid[0], m_bvalid[1], m_rvalid[0], m_rvalid[1]}, 4'b0000);
      @(negedge clk);
      s_bvalid = 1'b0; s_rvalid = 1'b0;
      #1;
      check("mrst.still_idle", {wr_gnt, rd_gnt, m_bvalid[0], m_rvalid[1]}, 6'd0);
      idle_all();
      do_txn(vecs[0], "mrst.fresh");
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
